// File: rtl/adding_machine_controller.sv
// Fetch/decode/execute control FSM for the adding-machine datapath.
// Drives datapath strobes and the memory handshake; halts with bus_err on memory timeout.
module adding_machine_controller #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] ir_opcode,
    input  logic       mem_ready,
    output logic       load_IR,
    output logic       load_acc,
    output logic       sel_alu,
    output logic       pass_add,
    output logic       sel_bus,
    output logic       ld_pc,
    output logic       clr_pc,
    output logic       inc_pc,
    output logic       ir_on_adr,
    output logic       pc_on_adr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_LDA    = 3'd3,
        S_STA    = 3'd4,
        S_ADD    = 3'd5,
        S_JMP    = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TO_W-1:0] r_wait_cnt;
    logic            w_waiting;
    logic            w_timeout;

    // Memory-access states are the only ones that can stall on mem_ready.
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_LDA) ||
                       (r_state == S_STA)   || (r_state == S_ADD);
    assign w_timeout = w_waiting && !mem_ready &&
                       (r_wait_cnt == TO_W'(TIMEOUT - 1));
    assign state     = r_state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_RST;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (!w_waiting || mem_ready || w_timeout)
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
            end
            S_DECODE: begin
                case (ir_opcode)
                    2'b00:   w_next = S_LDA;
                    2'b01:   w_next = S_STA;
                    2'b10:   w_next = S_ADD;
                    default: w_next = S_JMP;
                endcase
            end
            S_LDA, S_STA, S_ADD: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_HALT;
            end
            S_JMP:    w_next = S_FETCH;
            default:  w_next = S_HALT;
        endcase
    end

    always_comb begin
        load_IR   = 1'b0;
        load_acc  = 1'b0;
        sel_alu   = 1'b0;
        pass_add  = 1'b0;
        sel_bus   = 1'b0;
        ld_pc     = 1'b0;
        clr_pc    = 1'b0;
        inc_pc    = 1'b0;
        ir_on_adr = 1'b0;
        pc_on_adr = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        bus_err   = 1'b0;
        case (r_state)
            S_RST:   clr_pc = 1'b1;
            S_FETCH: begin
                pc_on_adr = 1'b1;
                mem_rd    = 1'b1;
                load_IR   = mem_ready;
                inc_pc    = mem_ready;
            end
            S_LDA, S_ADD: begin
                ir_on_adr = 1'b1;
                mem_rd    = 1'b1;
                pass_add  = (r_state == S_ADD);
                load_acc  = mem_ready;
                sel_alu   = mem_ready;
            end
            S_STA: begin
                ir_on_adr = 1'b1;
                sel_bus   = 1'b1;
                mem_wr    = 1'b1;
            end
            S_JMP: begin
                ir_on_adr = 1'b1;
                ld_pc     = 1'b1;
            end
            S_HALT:  bus_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_adding_machine_controller.sv
// Self-checking bench: directed literal scenarios, then randomized stimulus
// compared every cycle against an instruction-level behavioural model.
module tb_adding_machine_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] ir_opcode = 2'b10;
    logic       mem_ready = 1'b0;
    logic load_IR, load_acc, sel_alu, pass_add, sel_bus, ld_pc, clr_pc, inc_pc;
    logic ir_on_adr, pc_on_adr, mem_rd, mem_wr, bus_err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] LIR  = 13'h1000;
    localparam logic [12:0] LACC = 13'h0800;
    localparam logic [12:0] SALU = 13'h0400;
    localparam logic [12:0] PADD = 13'h0200;
    localparam logic [12:0] SBUS = 13'h0100;
    localparam logic [12:0] LDPC = 13'h0080;
    localparam logic [12:0] CLR  = 13'h0040;
    localparam logic [12:0] INC  = 13'h0020;
    localparam logic [12:0] IRA  = 13'h0010;
    localparam logic [12:0] PCA  = 13'h0008;
    localparam logic [12:0] RD   = 13'h0004;
    localparam logic [12:0] WR   = 13'h0002;
    localparam logic [12:0] BERR = 13'h0001;

    adding_machine_controller #(.TIMEOUT(15), .TO_W(4)) dut (
        .clock(clock), .reset(reset), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
        .load_IR(load_IR), .load_acc(load_acc), .sel_alu(sel_alu), .pass_add(pass_add),
        .sel_bus(sel_bus), .ld_pc(ld_pc), .clr_pc(clr_pc), .inc_pc(inc_pc),
        .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .bus_err(bus_err), .state(state)
    );

    always #5 clock = ~clock;

    logic [12:0] dut_o;
    assign dut_o = {load_IR, load_acc, sel_alu, pass_add, sel_bus, ld_pc, clr_pc,
                    inc_pc, ir_on_adr, pc_on_adr, mem_rd, mem_wr, bus_err};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase numbers are the architected debug codes; strobes follow
    // from which bus transaction the current instruction step performs.
    int m_st   = 0;
    int m_wait = 0;

    function automatic logic [12:0] exp_out(input int st, input logic rdy);
        case (st)
            0: return CLR;
            1: return PCA | RD | (rdy ? (LIR | INC) : 13'h0);
            3: return IRA | RD | (rdy ? (LACC | SALU) : 13'h0);
            4: return IRA | SBUS | WR;
            5: return IRA | RD | PADD | (rdy ? (LACC | SALU) : 13'h0);
            6: return IRA | LDPC;
            7: return BERR;
            default: return 13'h0;
        endcase
    endfunction

    always @(negedge clock) begin
        int nxt;
        logic [12:0] e;
        if (!reset) begin
            m_st   = 0;
            m_wait = 0;
        end
        e = exp_out(m_st, mem_ready);
        chk("model_state", {29'd0, state}, m_st);
        chk("model_strobes", {19'd0, dut_o}, {19'd0, e});
        chk("exclusive", {29'd0, (pc_on_adr & ir_on_adr), (mem_rd & mem_wr),
                          ((ld_pc + inc_pc + clr_pc) > 2'd1)}, 32'd0);
        nxt = m_st;
        if (!reset) nxt = 0;
        else if (m_st == 0) nxt = 1;
        else if (m_st == 2) nxt = 3 + ir_opcode;
        else if (m_st == 6) nxt = 1;
        else if (m_st == 7) nxt = 7;
        else if (mem_ready) begin
            nxt    = (m_st == 1) ? 2 : 1;
            m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait == 15) begin
                nxt    = 7;
                m_wait = 0;
            end
        end
        if (nxt != m_st && nxt == 7) m_wait = 0;
        if (m_st == 2 || m_st == 6) m_wait = 0;
        m_st = nxt;
    end

    task automatic cyc(input logic rst, input logic rdy, input logic [1:0] op);
        @(posedge clock);
        #1;
        reset     = rst;
        mem_ready = rdy;
        ir_opcode = op;
        @(negedge clock);
        #1;
    endtask

    task automatic lit(input string name, input logic [2:0] st, input logic [12:0] o);
        chk({name, "_state"}, {29'd0, state}, {29'd0, st});
        chk({name, "_out"}, {19'd0, dut_o}, {19'd0, o});
    endtask

    initial begin
        int mode_lo;
        // reset, then reset again in the middle of an ADD wait
        cyc(0, 0, 2'b10); lit("rst_hold", 3'd0, CLR);
        cyc(1, 0, 2'b10); lit("rst_release", 3'd0, CLR);
        cyc(1, 1, 2'b10); lit("fetch0", 3'd1, PCA | RD | LIR | INC);
        cyc(1, 0, 2'b10); lit("decode0", 3'd2, 13'h0);
        cyc(1, 0, 2'b10); lit("add_wait0", 3'd5, IRA | RD | PADD);
        cyc(0, 0, 2'b10); lit("rst_midadd", 3'd0, CLR);
        cyc(1, 0, 2'b00); lit("rst_one_cycle", 3'd0, CLR);
        cyc(1, 0, 2'b00); lit("fetch_wait", 3'd1, PCA | RD);
        // LDA zero-wait
        cyc(1, 1, 2'b00); lit("lda_fetch", 3'd1, PCA | RD | LIR | INC);
        cyc(1, 0, 2'b00); lit("lda_decode", 3'd2, 13'h0);
        cyc(1, 1, 2'b00); lit("lda_exec", 3'd3, IRA | RD | LACC | SALU);
        // ADD with 3 wait cycles
        cyc(1, 1, 2'b10); lit("add_fetch", 3'd1, PCA | RD | LIR | INC);
        cyc(1, 0, 2'b10); lit("add_decode", 3'd2, 13'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, k == 3, 2'b10);
            lit("add_exec", 3'd5, IRA | RD | PADD | ((k == 3) ? (LACC | SALU) : 13'h0));
        end
        // STA with 2 wait cycles
        cyc(1, 1, 2'b01); lit("sta_fetch", 3'd1, PCA | RD | LIR | INC);
        cyc(1, 0, 2'b01); lit("sta_decode", 3'd2, 13'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, k == 2, 2'b01); lit("sta_exec", 3'd4, IRA | SBUS | WR);
        end
        // JMP, then FETCH waits 14 cycles and completes on the 15th
        cyc(1, 1, 2'b11); lit("jmp_fetch", 3'd1, PCA | RD | LIR | INC);
        cyc(1, 0, 2'b11); lit("jmp_decode", 3'd2, 13'h0);
        cyc(1, 0, 2'b11); lit("jmp_exec", 3'd6, IRA | LDPC);
        cyc(1, 0, 2'b11); lit("jmp_next_fetch", 3'd1, PCA | RD);
        for (int k = 2; k <= 14; k++) begin
            cyc(1, 0, 2'b11); lit("fetch_wait14", 3'd1, PCA | RD);
        end
        cyc(1, 1, 2'b11); lit("ready_on_15th", 3'd1, PCA | RD | LIR | INC);
        cyc(1, 0, 2'b11); lit("decode_after_15", 3'd2, 13'h0);
        cyc(1, 0, 2'b11); lit("jmp2_exec", 3'd6, IRA | LDPC);
        // 15 unready cycles -> HALT
        for (int k = 1; k <= 15; k++) begin
            cyc(1, 0, 2'b11); lit("fetch_wait15", 3'd1, PCA | RD);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 2'b11); lit("halt", 3'd7, BERR);
        end
        cyc(0, 1, 2'b11); lit("halt_reset", 3'd0, CLR);

        // randomized phase: alternate responsive and sluggish memory
        for (int n = 0; n < 4000; n++) begin
            logic rst, rdy;
            mode_lo = ((n / 300) % 2);
            rst = ($urandom_range(0, 149) != 0);
            if (mode_lo != 0) rdy = ($urandom_range(0, 24) == 0);
            else              rdy = ($urandom_range(0, 9) < 7);
            cyc(rst, rdy, 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
